// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - instruction queue with registered MIPS-style decode stage.
// Optional HI/LO interlock enabled by defining DECODE_MULDIV_INTERLOCK_EN.
module decode_queue #(
  parameter int DEPTH      = 4,
  parameter int MULDIV_LAT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        AnyStall,
  input  logic [31:0] FetchData_IF,
  input  logic        FetchValid_IF,
  output logic        FetchReady_ID,
  output logic        Valid_ID,
  output logic        Jump_ID,
  output logic        Link_ID,
  output logic        RegWrite_ID,
  output logic        RegDst_ID,
  output logic        AluSrc_ID,
  output logic        MemWrite_ID,
  output logic        MemToReg_ID,
  output logic        Illegal_ID,
  output logic        MdBusy_ID,
  output logic [25:0] JumpTgt_ID,
  output logic [15:0] Imm_ID,
  output logic [2:0]  BpCtl_ID,
  output logic [3:0]  AluControl_ID
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

  if (MULDIV_LAT < 1 || MULDIV_LAT > 255 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
    $error("decode_queue: illegal parameter value");
  end

  typedef struct packed {
    logic        valid;
    logic        jump;
    logic        link;
    logic        reg_write;
    logic        reg_dst;
    logic        alu_src;
    logic        mem_write;
    logic        mem_to_reg;
    logic        illegal;
    logic [25:0] jump_tgt;
    logic [15:0] imm;
    logic [2:0]  bp_ctl;
    logic [3:0]  alu_control;
  } dec_t;

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  dec_t          out_q, out_d;
  dec_t          head_dec;
  logic [31:0]   head;
  logic [5:0]    op, fn;
  logic [4:0]    rt;
  logic [4:0]    ctl;
  logic          push, pop, interlock;

  assign head          = mem_q[rd_ptr_q];
  assign op            = head[31:26];
  assign fn            = head[5:0];
  assign rt            = head[20:16];
  assign FetchReady_ID = (count_q < DEPTH_C);
  assign push          = FetchValid_IF && FetchReady_ID && !flush;
  assign pop           = (count_q != '0) && !AnyStall && !flush && !interlock;

  always_comb begin
    head_dec          = '0;
    head_dec.valid    = 1'b1;
    head_dec.jump_tgt = head[25:0];
    head_dec.imm      = head[15:0];
    ctl               = 5'b00000;
    case (op)
      6'b000000: begin
        ctl = 5'b11000;
        case (fn)
          6'b011000:            head_dec.alu_control = 4'b1111;
          6'b011010:            head_dec.alu_control = 4'b1110;
          6'b100100:            head_dec.alu_control = 4'b0000;
          6'b100101:            head_dec.alu_control = 4'b0001;
          6'b100000, 6'b100001: head_dec.alu_control = 4'b0010;
          6'b100110:            head_dec.alu_control = 4'b0101;
          6'b100010, 6'b100011: head_dec.alu_control = 4'b0110;
          6'b101010, 6'b101011: head_dec.alu_control = 4'b0111;
          6'b010000:            head_dec.alu_control = 4'b1010;
          6'b010010:            head_dec.alu_control = 4'b1011;
          6'b000110:            head_dec.alu_control = 4'b0100;
          6'b000010:            head_dec.alu_control = 4'b1101;
          6'b000000:            head_dec.alu_control = 4'b1100;
          6'b000100:            head_dec.alu_control = 4'b0011;
          6'b000011:            head_dec.alu_control = 4'b1110;
          default:              head_dec.alu_control = 4'b0000;
        endcase
      end
      // REGIMM: the "AL" forms (bgezal/bltzal) also link
      6'b000001: begin
        case (rt)
          5'b00001: head_dec.bp_ctl = 3'b010;
          5'b10001: begin head_dec.bp_ctl = 3'b011; head_dec.link = 1'b1; end
          5'b00000: head_dec.bp_ctl = 3'b110;
          5'b10000: begin head_dec.bp_ctl = 3'b111; head_dec.link = 1'b1; end
          default:  head_dec.bp_ctl = 3'b000;
        endcase
      end
      6'b000010: head_dec.jump = 1'b1;
      6'b000011: begin head_dec.jump = 1'b1; head_dec.link = 1'b1; end
      6'b000100: begin head_dec.alu_control = 4'b0110; head_dec.bp_ctl = 3'b001; end
      6'b000101: head_dec.alu_control = 4'b0110;
      6'b000110: head_dec.bp_ctl = 3'b100;
      6'b000111: head_dec.bp_ctl = 3'b101;
      6'b001000, 6'b001001: begin ctl = 5'b10100; head_dec.alu_control = 4'b0010; end
      6'b001010: begin ctl = 5'b10100; head_dec.alu_control = 4'b0111; end
      6'b001100: begin ctl = 5'b10100; head_dec.alu_control = 4'b0000; end
      6'b001101: begin ctl = 5'b10100; head_dec.alu_control = 4'b0001; end
      6'b001110, 6'b001111: begin ctl = 5'b10100; head_dec.alu_control = 4'b1001; end
      6'b100011: begin ctl = 5'b10101; head_dec.alu_control = 4'b0010; end
      6'b101011: begin ctl = 5'b00110; head_dec.alu_control = 4'b0010; end
      default:   head_dec.illegal = 1'b1;
    endcase
    {head_dec.reg_write, head_dec.reg_dst, head_dec.alu_src,
     head_dec.mem_write, head_dec.mem_to_reg} = ctl;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    out_d    = out_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      out_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (PW + 1)'(push) - (PW + 1)'(pop);
      if (!AnyStall) out_d = pop ? head_dec : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      out_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      out_q    <= out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= FetchData_IF;
  end

`ifdef DECODE_MULDIV_INTERLOCK_EN
  logic [7:0] busy_cnt_q, busy_cnt_d;
  logic       md_busy_q, md_busy_d;
  logic       head_is_md, head_is_mf;

  assign head_is_md = (op == 6'b000000) && (fn == 6'b011000 || fn == 6'b011010);
  assign head_is_mf = (op == 6'b000000) && (fn == 6'b010000 || fn == 6'b010010);
  // mfhi/mflo may issue on the edge where the counter drains to zero
  assign interlock  = head_is_mf && (busy_cnt_q > 8'd1);

  always_comb begin
    busy_cnt_d = busy_cnt_q - {7'd0, (busy_cnt_q != 8'd0)};
    if (pop && head_is_md) busy_cnt_d = 8'(MULDIV_LAT);
    md_busy_d = (busy_cnt_d != 8'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_cnt_q <= 8'd0;
      md_busy_q  <= 1'b0;
    end else begin
      busy_cnt_q <= busy_cnt_d;
      md_busy_q  <= md_busy_d;
    end
  end

  assign MdBusy_ID = md_busy_q;
`else
  assign interlock = 1'b0;
  assign MdBusy_ID = 1'b0;
`endif

  assign Valid_ID      = out_q.valid;
  assign Jump_ID       = out_q.jump;
  assign Link_ID       = out_q.link;
  assign RegWrite_ID   = out_q.reg_write;
  assign RegDst_ID     = out_q.reg_dst;
  assign AluSrc_ID     = out_q.alu_src;
  assign MemWrite_ID   = out_q.mem_write;
  assign MemToReg_ID   = out_q.mem_to_reg;
  assign Illegal_ID    = out_q.illegal;
  assign JumpTgt_ID    = out_q.jump_tgt;
  assign Imm_ID        = out_q.imm;
  assign BpCtl_ID      = out_q.bp_ctl;
  assign AluControl_ID = out_q.alu_control;

endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - randomized bench for decode_queue against a queue-based reference model.
module tb_decode_queue;

  localparam int DEPTH = 4;
  localparam int LAT   = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        AnyStall;
  logic [31:0] FetchData_IF;
  logic        FetchValid_IF;
  logic        FetchReady_ID, Valid_ID, Jump_ID, Link_ID, RegWrite_ID, RegDst_ID;
  logic        AluSrc_ID, MemWrite_ID, MemToReg_ID, Illegal_ID, MdBusy_ID;
  logic [25:0] JumpTgt_ID;
  logic [15:0] Imm_ID;
  logic [2:0]  BpCtl_ID;
  logic [3:0]  AluControl_ID;

  decode_queue #(.DEPTH(DEPTH), .MULDIV_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .flush(flush), .AnyStall(AnyStall),
    .FetchData_IF(FetchData_IF), .FetchValid_IF(FetchValid_IF),
    .FetchReady_ID(FetchReady_ID), .Valid_ID(Valid_ID), .Jump_ID(Jump_ID),
    .Link_ID(Link_ID), .RegWrite_ID(RegWrite_ID), .RegDst_ID(RegDst_ID),
    .AluSrc_ID(AluSrc_ID), .MemWrite_ID(MemWrite_ID), .MemToReg_ID(MemToReg_ID),
    .Illegal_ID(Illegal_ID), .MdBusy_ID(MdBusy_ID), .JumpTgt_ID(JumpTgt_ID),
    .Imm_ID(Imm_ID), .BpCtl_ID(BpCtl_ID), .AluControl_ID(AluControl_ID)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic valid, jump, link, rw, rd, as, mw, mtr, ill;
    logic [3:0]  alu;
    logic [2:0]  bp;
    logic [15:0] imm;
    logic [25:0] tgt;
  } exp_t;

  // {funct, AluControl} pairs
  localparam logic [9:0] FN_TAB [18] = '{
    {6'b011000, 4'b1111}, {6'b011010, 4'b1110}, {6'b100100, 4'b0000}, {6'b100101, 4'b0001},
    {6'b100000, 4'b0010}, {6'b100001, 4'b0010}, {6'b100110, 4'b0101}, {6'b100010, 4'b0110},
    {6'b100011, 4'b0110}, {6'b101010, 4'b0111}, {6'b101011, 4'b0111}, {6'b010000, 4'b1010},
    {6'b010010, 4'b1011}, {6'b000110, 4'b0100}, {6'b000010, 4'b1101}, {6'b000000, 4'b1100},
    {6'b000100, 4'b0011}, {6'b000011, 4'b1110}};
  localparam logic [5:0] OP_TAB [17] = '{
    6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10,
    6'd12, 6'd13, 6'd14, 6'd15, 6'd35, 6'd43};
  localparam logic [4:0] RT_TAB [4] = '{5'd0, 5'd1, 5'd16, 5'd17};

  localparam logic [31:0] W_MULT = 32'h0109_0018;
  localparam logic [31:0] W_MFLO = 32'h0000_5012;

  int total = 0;
  int bad   = 0;

  logic [31:0] mq[$];
  exp_t        m_out;
  int          cyc;
  int          mult_edge;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t       e;
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rt;
    op = w[31:26];
    fn = w[5:0];
    rt = w[20:16];
    e = '0;
    e.valid = 1'b1;
    e.imm = w[15:0];
    e.tgt = w[25:0];
    case (op)
      6'd0: begin
        {e.rw, e.rd, e.as, e.mw, e.mtr} = 5'b11000;
        for (int i = 0; i < 18; i++) if (FN_TAB[i][9:4] == fn) e.alu = FN_TAB[i][3:0];
      end
      6'd1: begin
        if (rt == 5'd1)  e.bp = 3'b010;
        if (rt == 5'd17) begin e.bp = 3'b011; e.link = 1'b1; end
        if (rt == 5'd0)  e.bp = 3'b110;
        if (rt == 5'd16) begin e.bp = 3'b111; e.link = 1'b1; end
      end
      6'd2: e.jump = 1'b1;
      6'd3: begin e.jump = 1'b1; e.link = 1'b1; end
      6'd4: begin e.alu = 4'b0110; e.bp = 3'b001; end
      6'd5: e.alu = 4'b0110;
      6'd6: e.bp = 3'b100;
      6'd7: e.bp = 3'b101;
      6'd8, 6'd9: begin {e.rw, e.rd, e.as, e.mw, e.mtr} = 5'b10100; e.alu = 4'b0010; end
      6'd10: begin {e.rw, e.rd, e.as, e.mw, e.mtr} = 5'b10100; e.alu = 4'b0111; end
      6'd12: begin {e.rw, e.rd, e.as, e.mw, e.mtr} = 5'b10100; e.alu = 4'b0000; end
      6'd13: begin {e.rw, e.rd, e.as, e.mw, e.mtr} = 5'b10100; e.alu = 4'b0001; end
      6'd14, 6'd15: begin {e.rw, e.rd, e.as, e.mw, e.mtr} = 5'b10100; e.alu = 4'b1001; end
      6'd35: begin {e.rw, e.rd, e.as, e.mw, e.mtr} = 5'b10101; e.alu = 4'b0010; end
      6'd43: begin {e.rw, e.rd, e.as, e.mw, e.mtr} = 5'b00110; e.alu = 4'b0010; end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  function automatic bit is_md(input logic [31:0] w);
    return w[31:26] == 6'd0 && (w[5:0] == 6'b011000 || w[5:0] == 6'b011010);
  endfunction

  function automatic bit is_mf(input logic [31:0] w);
    return w[31:26] == 6'd0 && (w[5:0] == 6'b010000 || w[5:0] == 6'b010010);
  endfunction

  // HI/LO result is ready LAT edges after the mult/div issued
  function automatic bit hilo_busy(input int edge_idx);
`ifdef DECODE_MULDIV_INTERLOCK_EN
    return (edge_idx - mult_edge) < LAT;
`else
    return edge_idx < 0;
`endif
  endfunction

  task automatic model_reset();
    mq.delete();
    m_out = '0;
    mult_edge = -1000000;
  endtask

  task automatic model_step(input logic v, input logic [31:0] w, input logic st, input logic fl);
    bit          take;
    logic [31:0] hw;
    cyc++;
    if (fl) begin
      mq.delete();
      m_out = '0;
    end else begin
      take = v && (mq.size() < DEPTH);
      if (!st) begin
        if (mq.size() > 0 && !(is_mf(mq[0]) && hilo_busy(cyc))) begin
          hw = mq.pop_front();
          m_out = ref_decode(hw);
          if (is_md(hw)) mult_edge = cyc;
        end else begin
          m_out = '0;
        end
      end
      if (take) mq.push_back(w);
    end
  endtask

  task automatic compare_all();
    exp_t d;
    d = '{Valid_ID, Jump_ID, Link_ID, RegWrite_ID, RegDst_ID, AluSrc_ID, MemWrite_ID,
          MemToReg_ID, Illegal_ID, AluControl_ID, BpCtl_ID, Imm_ID, JumpTgt_ID};
    check("rdy", FetchReady_ID, mq.size() < DEPTH);
    check("ctl", d[57:42], m_out[57:42]);
    check("fld", d[41:0], m_out[41:0]);
    check("mdbusy", MdBusy_ID, hilo_busy(cyc));
  endtask

  task automatic step(input logic v, input logic [31:0] w, input logic st, input logic fl);
    @(negedge clk);
    compare_all();
    FetchValid_IF = v;
    FetchData_IF  = w;
    AnyStall      = st;
    flush         = fl;
    model_step(v, w, st, fl);
    @(posedge clk);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 18) < 17) w[31:26] = OP_TAB[$urandom_range(0, 16)];
    if (w[31:26] == 6'd0 && $urandom_range(0, 4) != 0) w[5:0] = FN_TAB[$urandom_range(0, 17)][9:4];
    if (w[31:26] == 6'd0 && $urandom_range(0, 3) == 0) w[5:0] = ($urandom_range(0, 1) != 0) ? W_MULT[5:0] : W_MFLO[5:0];
    if (w[31:26] == 6'd1 && $urandom_range(0, 4) != 0) w[20:16] = RT_TAB[$urandom_range(0, 3)];
    return w;
  endfunction

  initial begin
    int gap;
    reset = 1'b1; flush = 1'b0; AnyStall = 1'b0; FetchValid_IF = 1'b0; FetchData_IF = '0;
    cyc = 0;
    model_reset();
    #3;
    check("rst_rdy", FetchReady_ID, 1'b1);
    check("rst_valid", Valid_ID, 1'b0);
    check("rst_ctl", {RegWrite_ID, AluSrc_ID, Illegal_ID, AluControl_ID}, 7'd0);
    check("rst_mdbusy", MdBusy_ID, 1'b0);
    #3 reset = 1'b0;

    // ADDI pushed at edge 1 appears after edge 2, not earlier
    step(1'b1, 32'h2008_0005, 1'b0, 1'b0);
    #2 check("nobypass_valid", Valid_ID, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    check("addi_valid", Valid_ID, 1'b1);
    check("addi_rw_as", {RegWrite_ID, AluSrc_ID}, 2'b11);
    check("addi_alu", AluControl_ID, 4'b0010);
    check("addi_imm", Imm_ID, 16'h0005);

    // fill under stall, overflow word dropped, drain across pointer wrap
    for (int i = 0; i <= DEPTH; i++) begin
      step(1'b1, 32'h2008_0010 + 32'(i), 1'b1, 1'b0);
      if (i == DEPTH - 1) #2 check("full_rdy", FetchReady_ID, 1'b0);
    end
    for (int i = 0; i <= DEPTH; i++) begin
      step(1'b0, 32'h0, 1'b0, 1'b0);
      #2 check("wrap_order", {Valid_ID, Imm_ID}, (i < DEPTH) ? {1'b1, 16'h0010 + 16'(i)} : 17'd0);
    end

    // flush with three entries queued and a word arriving
    for (int i = 0; i < 3; i++) step(1'b1, 32'h3409_0000 + 32'(i), 1'b1, 1'b0);
    step(1'b1, 32'h2008_0077, 1'b0, 1'b1);
    #2;
    check("flush_valid", Valid_ID, 1'b0);
    check("flush_rdy", FetchReady_ID, 1'b1);

    // BGEZAL then an illegal opcode
    step(1'b1, 32'h0411_0010, 1'b0, 1'b0);
    step(1'b1, 32'hFC00_0000, 1'b0, 1'b0);
    #2 check("bgezal_bp_link", {BpCtl_ID, Link_ID}, {3'b011, 1'b1});
    step(1'b0, 32'h0, 1'b0, 1'b0);
    #2 check("illegal_flags", {Valid_ID, Illegal_ID, RegWrite_ID}, 3'b110);

    // mult followed by mflo
    step(1'b1, W_MULT, 1'b1, 1'b0);
    step(1'b1, W_MFLO, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    #2 check("mult_issue", AluControl_ID, 4'b1111);
    gap = 0;
    for (int k = 0; k < 30; k++) begin
      step(1'b0, 32'h0, 1'b0, 1'b0);
      #2 gap++;
      if (Valid_ID && AluControl_ID == 4'b1011) break;
    end
`ifdef DECODE_MULDIV_INTERLOCK_EN
    check("mflo_gap", gap, LAT);
`else
    check("mflo_gap", gap, 1);
`endif

    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 99) < 60, rand_word(), $urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 4);
      if (n == 300) begin
        #2 reset = 1'b1;
        #1;
        check("mid_rst_valid", Valid_ID, 1'b0);
        check("mid_rst_rdy", FetchReady_ID, 1'b1);
        check("mid_rst_mdbusy", MdBusy_ID, 1'b0);
        model_reset();
        #1 reset = 1'b0;
      end
    end
    @(negedge clk);
    compare_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
